// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a 4:1 data mux with a bounded hold time per owner.
// A grant ends on done, when the owner drops its request, or after MAX_HOLD cycles.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // The hold counter starts at zero on the first owned cycle, so MAX_HOLD-1 is the last one.
  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);

  logic [0:0] state;
  logic [1:0] last;
  logic [3:0] hold;
  logic [1:0] winner;
  logic       release_now;

  // Searching from last+1 and wrapping ends on last itself, so the owner is only re-picked when alone.
  function automatic logic [1:0] rr_pick(input logic [1:0] from, input logic [3:0] r);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = from;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = from + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    winner      = rr_pick(last, req);
    release_now = done || !req[sel] || (hold == HOLD_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      last  <= 2'd3;
      hold  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            state <= GRANT;
            gnt   <= 4'b0001 << winner;
            sel   <= winner;
            last  <= winner;
            hold  <= 4'd0;
          end
        end
        GRANT: begin
          if (release_now) begin
            hold <= 4'd0;
            if (req != 4'b0000) begin
              gnt  <= 4'b0001 << winner;
              sel  <= winner;
              last <= winner;
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
            end
          end else begin
            hold <= hold + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
        end
      endcase
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive cycles one requester may own the mux; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  request lines; bit n = requester n wants mux input n.
REQ-005 done  input  1  current owner finishes its transfer; valid only while busy=1.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 sel  output  2  mux select {s1,s0} = index of current or most recent owner; drives the 4:1 data mux directly.
REQ-008 busy  output  1  high while a grant is active.

Function
REQ-009 The FSM SHALL have two states: IDLE (busy=0, gnt=0) and GRANT (busy=1, gnt one-hot).
REQ-010 The arbiter SHALL keep a 2-bit last-owner pointer; the winner is the first set req bit searched from (last+1) mod 4 upward, wrapping 3->0.
REQ-011 In IDLE with req != 0, the next cycle SHALL enter GRANT with gnt=1<<winner, sel=winner, last=winner, hold counter=0 (request-to-grant latency 1 cycle).
REQ-012 In IDLE with req = 0, state, sel and last SHALL hold; done SHALL be ignored.
REQ-013 In GRANT, a 4-bit hold counter SHALL increment every cycle the grant is retained.
REQ-014 Release SHALL occur on the first cycle in GRANT where done=1, req[owner]=0, or hold counter = MAX_HOLD-1 (timeout).
REQ-015 On release with req != 0, the next cycle SHALL grant the round-robin winner computed from the current owner (back-to-back, no idle cycle, counter cleared).
REQ-016 On release, the current owner SHALL be re-granted only if no other req bit is set.
REQ-017 On release with req = 0, the next cycle SHALL be IDLE with gnt=0, busy=0, sel held at the last owner.
REQ-018 Multiple release causes in one cycle SHALL be treated as a single release.
REQ-019 gnt SHALL never have more than one bit set; sel SHALL equal the index of the gnt bit whenever busy=1.
REQ-020 With MAX_HOLD=1, every grant SHALL last exactly one cycle, and contending requesters SHALL rotate every cycle.

Reset
REQ-021 While rst=1 at a clock edge: state=IDLE, gnt=0000, sel=00, busy=0, hold counter=0, last=3, so requester 0 has top priority after reset.
REQ-022 Reset SHALL take priority over all other inputs, including mid-grant; gnt SHALL be 0000 on the cycle after reset is sampled.

Verification
REQ-023 Reset, then req=0001 -> one cycle later gnt=0001, sel=00, busy=1.
REQ-024 req=1111 held, done pulsed each owned cycle -> grant sequence 0001,0010,0100,1000,0001; sel 0,1,2,3,0; no idle gaps.
REQ-025 MAX_HOLD=8, req=0101 held, done=0 -> requester 0 granted 8 cycles, then requester 2 granted 8 cycles, alternating.
REQ-026 req=0010 only, held with done=0 -> timeout after 8 cycles, then requester 1 re-granted immediately with counter restarted; busy stays 1.
REQ-027 Owner drops req while others idle -> next cycle gnt=0000, busy=0, sel unchanged.
REQ-028 rst=1 during a grant to requester 2 -> next cycle gnt=0000, sel=00; with req=1111 after reset, requester 0 is granted first.
